instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning output FIFO entry count (power of two, >=2).
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port inValid, input, 1, field request present.
REQ-005 SHALL have port inReady, output, 1, encoder can accept a request this cycle.
REQ-006 SHALL have port format, input, 3, encoding: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are invalid.
REQ-007 SHALL have ports opcode (input, 7), funct3 (input, 3) and funct7 (input, 7), the instruction fields.
REQ-008 SHALL have ports rdAddress, rs1Address and rs2Address, each input, 5, register addresses.
REQ-009 SHALL have port immediate, input, 32, full-width unscrambled immediate.
REQ-010 SHALL have ports outValid (output, 1), outReady (input, 1) and instruction (output, 32), the encoded word stream.
REQ-011 SHALL have port count, output, log2(DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have ports error (output, 1, sticky range/format fault) and errorClear (input, 1, clears error).

Function
REQ-013 SHALL accept a request on a cycle where inValid && inReady; inReady = (count != DEPTH).
REQ-014 SHALL pack R as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-015 SHALL pack I as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-016 SHALL pack S as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-017 SHALL pack B as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-018 SHALL pack U as {imm[31:12], rd, opcode}.
REQ-019 SHALL pack J as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-020 SHALL ignore fields not used by the selected format.
REQ-021 SHALL enqueue the encoded word into the FIFO in the accept cycle; the word SHALL be visible on instruction with outValid high no earlier than the next cycle (latency 1 when empty).
REQ-022 SHALL drive outValid = (count != 0) and pop the head on outValid && outReady.
REQ-023 SHALL hold instruction stable while outValid && !outReady.
REQ-024 SHALL leave count unchanged on a simultaneous push and pop and preserve FIFO order.
REQ-025 SHALL NOT accept a push when full, even if a pop occurs in the same cycle.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL drive instruction to 0 when the FIFO is empty.
REQ-028 SHALL clear error on errorClear; a fault in the same cycle SHALL take priority and leave error set.

Reset
REQ-029 SHALL on reset set count=0, outValid=0, instruction=0, error=0, pointers=0, discarding all contents, including mid-stream.
REQ-030 SHALL hold inReady high in the cycle after reset.

Configuration
REQ-031 SHALL compile range checking in only when INSTRUCTION_ENCODER_RANGE_CHECK_EN is defined.
REQ-032 With the macro defined, each request SHALL be checked as faulting when any of these holds: I/S imm[31:11] not all equal; B imm[31:12] not all equal or imm[0]=1; J imm[31:20] not all equal or imm[0]=1; U imm[11:0] != 0; format 6 or 7.
REQ-033 With the macro defined, a faulting request SHALL be accepted (consumed per REQ-013) but not enqueued, and error SHALL be set the next cycle.
REQ-034 Without the macro, no check SHALL be made, out-of-range bits SHALL be truncated, format 6/7 SHALL encode 32'h00000013, and error SHALL be tied 0.

Verification
REQ-035 R case: format=0, opcode=0x33, funct7=0x20, funct3=0, rd=3, rs1=1, rs2=2 -> instruction=0x402081B3 one cycle after accept.
REQ-036 I case: format=1, opcode=0x13, rd=1, rs1=0, imm=0xFFFFFFFF -> instruction=0xFFF00093.
REQ-037 B case: format=3, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC -> instruction=0xFE208EE3.
REQ-038 FIFO full: push 4 distinct words with outReady=0 -> count=4, inReady=0; then outReady=1 with inValid=1 -> words drain in push order, and the next push is accepted only once count<4.
REQ-039 Range fault: format=1, imm=0x00000800 -> macro defined: count unchanged, error=1 until errorClear; macro undefined: instruction[31:20]=0x800, error=0.
REQ-040 Reset mid-operation: count=3 with outReady=0, assert reset one cycle -> next cycle count=0, outValid=0, instruction=0, error=0, inReady=1.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs RV32 R/I/S/B/U/J field requests into 32-bit words queued in a DEPTH-entry FIFO; 1-cycle latency when empty, inReady low when full.
// Define INSTRUCTION_ENCODER_RANGE_CHECK_EN to drop out-of-range requests and raise a sticky error.
module instruction_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [2:0]               format,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [4:0]               rdAddress,
  input  logic [4:0]               rs1Address,
  input  logic [4:0]               rs2Address,
  input  logic [31:0]              immediate,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [31:0]              instruction,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     error,
  input  logic                     errorClear
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   word;
  logic          fault;
  logic          accept;
  logic          push;
  logic          pop;

  always_comb begin
    word = 32'h0000_0013;
    case (format)
      3'd0: word = {funct7, rs2Address, rs1Address, funct3, rdAddress, opcode};
      3'd1: word = {immediate[11:0], rs1Address, funct3, rdAddress, opcode};
      3'd2: word = {immediate[11:5], rs2Address, rs1Address, funct3, immediate[4:0], opcode};
      3'd3: word = {immediate[12], immediate[10:5], rs2Address, rs1Address, funct3,
                    immediate[4:1], immediate[11], opcode};
      3'd4: word = {immediate[31:12], rdAddress, opcode};
      3'd5: word = {immediate[20], immediate[10:1], immediate[11], immediate[19:12],
                    rdAddress, opcode};
      default: word = 32'h0000_0013;
    endcase
  end

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
  // Sign-extension checks: upper bits must all match the immediate's sign bit.
  always_comb begin
    fault = 1'b0;
    case (format)
      3'd1, 3'd2: fault = !((&immediate[31:11]) || !(|immediate[31:11]));
      3'd3:       fault = !((&immediate[31:12]) || !(|immediate[31:12])) || immediate[0];
      3'd4:       fault = |immediate[11:0];
      3'd5:       fault = !((&immediate[31:20]) || !(|immediate[31:20])) || immediate[0];
      3'd6, 3'd7: fault = 1'b1;
      default:    fault = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      error <= 1'b0;
    end else if (accept && fault) begin
      error <= 1'b1;
    end else if (errorClear) begin
      error <= 1'b0;
    end
  end
`else
  logic unused_ok;
  assign fault     = 1'b0;
  assign error     = 1'b0;
  assign unused_ok = ^{errorClear, immediate[0]};
`endif

  assign inReady     = (count != FULL);
  assign outValid    = (count != '0);
  assign accept      = inValid && inReady;
  assign push        = accept && !fault;
  assign pop         = outValid && outReady;
  assign instruction = outValid ? mem[rd_ptr] : 32'h0;

  // Push is gated by inReady alone, so a full FIFO refuses even when popping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= word;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Table-driven and scoreboard bench for instruction_encoder (DEPTH=4).
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [2:0]  format;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rdAddress;
  logic [4:0]  rs1Address;
  logic [4:0]  rs2Address;
  logic [31:0] immediate;
  logic        outValid;
  logic        outReady;
  logic [31:0] instruction;
  logic [2:0]  count;
  logic        error;
  logic        errorClear;

  always #5 clock = ~clock;

  instruction_encoder #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .format(format), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rdAddress(rdAddress), .rs1Address(rs1Address), .rs2Address(rs2Address),
    .immediate(immediate), .outValid(outValid), .outReady(outReady),
    .instruction(instruction), .count(count), .error(error), .errorClear(errorClear)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    bit          bad;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] sb [$];
  logic [31:0] mon_exp;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          stream_on = 1'b0;
  bit          flt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && outValid && outReady) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_out: got 0x%08h, want no word", instruction);
      end else begin
        mon_exp = sb.pop_front();
        check("out_word", instruction, mon_exp);
      end
    end
  end

  function automatic vec_t mk_u(input logic [19:0] up, input logic [4:0] rd);
    vec_t v;
    v = '{3'd4, 7'h37, 3'd5, 7'h7F, rd, 5'd31, 5'd17, {up, 12'h000}, {up, rd, 7'h37}, 1'b0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    format     = v.fmt;
    opcode     = v.op;
    funct3     = v.f3;
    funct7     = v.f7;
    rdAddress  = v.rd;
    rs1Address = v.rs1;
    rs2Address = v.rs2;
    immediate  = v.imm;
    inValid    = 1'b1;
  endtask

  task automatic send(input vec_t v, input bit enq);
    int w = 0;
    drive(v);
    @(negedge clock);
    while (!inReady && w < 64) begin
      @(negedge clock);
      w++;
    end
    if (!inReady) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: inReady 0, want 1");
    end else if (enq) begin
      sb.push_back(v.exp);
    end
    @(posedge clock);
    #1;
    inValid = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd3,  5'd1,  5'd2,  32'h0000_0000, 32'h4020_81B3, 1'b0};
    tbl[1]  = '{3'd1, 7'h13, 3'd0, 7'h55, 5'd1,  5'd0,  5'd9,  32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    tbl[2]  = '{3'd3, 7'h63, 3'd0, 7'h7F, 5'd31, 5'd1,  5'd2,  32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
    tbl[3]  = '{3'd2, 7'h23, 3'd2, 7'h11, 5'd7,  5'd2,  5'd5,  32'h0000_0008, 32'h0051_2423, 1'b0};
    tbl[4]  = '{3'd4, 7'h37, 3'd7, 7'h7F, 5'd5,  5'd9,  5'd10, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    tbl[5]  = '{3'd5, 7'h6F, 3'd3, 7'h22, 5'd1,  5'd4,  5'd6,  32'h0000_0008, 32'h0080_00EF, 1'b0};
    tbl[6]  = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd10, 5'd11, 5'd12, 32'hDEAD_BEEF, 32'h00C5_8533, 1'b0};
    tbl[7]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd2,  5'd2,  5'd0,  32'hFFFF_FFF0, 32'hFF01_0113, 1'b0};
    tbl[8]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0};
    tbl[9]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h0000_0800, 32'h8000_0013, 1'b1};
    tbl[10] = '{3'd6, 7'h33, 3'd1, 7'h20, 5'd5,  5'd6,  5'd7,  32'h0000_0000, 32'h0000_0013, 1'b1};
    tbl[11] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h0000_0009, 32'h0000_0463, 1'b1};
    tbl[12] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h0000_1FFF, 32'h0000_1037, 1'b1};
    tbl[13] = '{3'd7, 7'h13, 3'd0, 7'h00, 5'd1,  5'd1,  5'd1,  32'h0000_0000, 32'h0000_0013, 1'b1};
    tbl[14] = '{3'd2, 7'h23, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0023, 1'b0};

    reset = 1'b1; inValid = 1'b0; outReady = 1'b0; errorClear = 1'b0;
    format = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rdAddress = '0; rs1Address = '0; rs2Address = '0; immediate = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_count", 32'(count), 0);
    check("rst_outValid", 32'(outValid), 0);
    check("rst_instruction", instruction, 0);
    check("rst_error", 32'(error), 0);
    check("rst_inReady", 32'(inReady), 1);
    @(posedge clock);
    #1;

    // Table: one word at a time with the consumer always ready.
    outReady = 1'b1;
    for (int i = 0; i < 15; i++) begin
`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
      flt = tbl[i].bad;
`else
      flt = 1'b0;
`endif
      send(tbl[i], !flt);
      @(negedge clock);
      if (flt) begin
        check($sformatf("v%0d_err_set", i), 32'(error), 1);
        check($sformatf("v%0d_count_kept", i), 32'(count), 0);
        @(posedge clock);
        #1 errorClear = 1'b1;
        @(posedge clock);
        #1 errorClear = 1'b0;
        @(negedge clock);
        check($sformatf("v%0d_err_clear", i), 32'(error), 0);
      end else begin
        check($sformatf("v%0d_latency", i), 32'(outValid), 1);
        check($sformatf("v%0d_err_zero", i), 32'(error), 0);
      end
      @(posedge clock);
      #1;
    end

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    // Fault and errorClear together: the fault wins.
    errorClear = 1'b1;
    send(tbl[9], 1'b0);
    errorClear = 1'b0;
    @(negedge clock);
    check("err_priority", 32'(error), 1);
    @(posedge clock);
    #1 errorClear = 1'b1;
    @(posedge clock);
    #1 errorClear = 1'b0;
`endif

    // Fill to full, hold, then drain with a pending push.
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) send(mk_u(20'hA0000 + 20'(i), 5'(i + 1)), 1'b1);
    @(negedge clock);
    check("full_count", 32'(count), 4);
    check("full_inReady", 32'(inReady), 0);
    check("full_head", instruction, 32'hA0000_0B7);
    @(negedge clock);
    check("full_hold", instruction, 32'hA0000_0B7);
    @(posedge clock);
    #1 outReady = 1'b1;
    drive(mk_u(20'hBEEF5, 5'd9));
    @(negedge clock);
    check("full_pop_noaccept", 32'(inReady), 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("after_pop_count", 32'(count), 3);
    check("after_pop_inReady", 32'(inReady), 1);
    sb.push_back({20'hBEEF5, 5'd9, 7'h37});
    @(posedge clock);
    #1 inValid = 1'b0;
    @(negedge clock);
    check("pushpop_count", 32'(count), 3);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clock);
    check("full_drained", 32'(sb.size()), 0);
    @(negedge clock);
    check("empty_instruction", instruction, 0);
    check("empty_outValid", 32'(outValid), 0);

    // Streaming with random backpressure across pointer wrap.
    @(posedge clock);
    #1 stream_on = 1'b1;
    fork
      begin
        while (stream_on) begin
          @(posedge clock);
          #1 outReady = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 24; i++) send(mk_u(20'($urandom), 5'($urandom_range(0, 31))), 1'b1);
    stream_on = 1'b0;
    @(posedge clock);
    #2 outReady = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clock);
    check("stream_drained", 32'(sb.size()), 0);
    @(posedge clock);
    #1;

    // Reset in the middle of a backlog.
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) send(mk_u(20'h00C00 + 20'(i), 5'd4), 1'b0);
`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    send(tbl[9], 1'b0);
    @(negedge clock);
    check("mid_err_set", 32'(error), 1);
`else
    @(negedge clock);
`endif
    check("mid_count", 32'(count), 3);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_outValid", 32'(outValid), 0);
    check("mid_rst_instruction", instruction, 0);
    check("mid_rst_error", 32'(error), 0);
    check("mid_rst_inReady", 32'(inReady), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
